// File: rtl/mux_nx1_scan_reg.sv
// mux_nx1_scan_reg
//   Parametrised N_CH-channel, WIDTH-bit registered multiplexer with a valid/ready output.
//   MANUAL mode (mode=0): the channel named by sel is captured whenever the output slot is free.
//   SCAN mode (mode=1): channels are captured round-robin (0..N_CH-1, wrap). The gap between
//   captures is set by dwell: with no stall, there is one capture every dwell+1 clocks.
//   Each captured sample appears on dout/ch_out one clock after the capture decision.
//   It is held stable while out_valid && !out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high (wins over everything)
//   din        flattened channels, channel k = din[k*WIDTH +: WIDTH]
//   sel        channel select (MANUAL only)
//   mode       0 = MANUAL, 1 = SCAN
//   en         capture enable
//   dwell      SCAN idle cycles between captures
//   out_ready  consumer accepts dout this cycle
//   out_valid  dout/ch_out hold a sample
//   dout       captured sample
//   ch_out     channel index of dout
//   sel_err    one-clock pulse: MANUAL capture attempted with sel >= N_CH
module mux_nx1_scan_reg #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned DWELL_W = 4,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      ch_out,
  output logic                  sel_err
);

  localparam logic [SEL_W:0]   NChW   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {StIdle, StWait, StCapt} scan_state_e;

  scan_state_e          state_q, state_d;
  logic [SEL_W-1:0]     scan_ptr_q, scan_ptr_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                 mode_q;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0]     ch_out_q, ch_out_d;
  logic                 sel_err_q, sel_err_d;

  logic                 mode_rise;
  logic [SEL_W-1:0]     ptr_cur;
  logic [DWELL_W-1:0]   cnt_cur;
  logic                 slot_free;
  logic                 tick;
  logic                 sel_ok;
  logic                 load;
  logic [SEL_W-1:0]     cap_ch;
  logic [WIDTH-1:0]     cap_data;

  // Entering SCAN restarts the sweep at channel 0. The restart takes effect in the same
  // cycle, so a dwell of 0 captures channel 0 on the first SCAN clock.
  assign mode_rise = mode && !mode_q;
  assign ptr_cur   = mode_rise ? '0 : scan_ptr_q;
  assign cnt_cur   = mode_rise ? '0 : dwell_cnt_q;

  assign slot_free = !out_valid_q || out_ready;
  // Using >= rather than == means that lowering dwell below the running count ends the wait.
  assign tick      = !mode || (cnt_cur >= dwell);
  assign sel_ok    = ({1'b0, sel} < NChW);
  assign load      = en && tick && slot_free && (mode || sel_ok);
  assign cap_ch    = mode ? ptr_cur : sel;

  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (cap_ch == SEL_W'(k)) begin
        cap_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Scan sequencer. The IDLE state is treated as the first counting cycle of WAIT.
  // This gives dwell+1 clocks from enable to the first capture.
  always_comb begin
    state_d     = state_q;
    scan_ptr_d  = ptr_cur;
    dwell_cnt_d = cnt_cur;

    if (!(mode && en)) begin
      state_d     = StIdle;
      dwell_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StWait, StCapt: begin
          if (!tick) begin
            dwell_cnt_d = cnt_cur + 1'b1;
            state_d     = StWait;
          end else if (!slot_free) begin
            // Dwell done but the consumer is stalling: park with count held.
            state_d = StCapt;
          end else begin
            scan_ptr_d  = (ptr_cur == LastCh) ? '0 : ptr_cur + 1'b1;
            dwell_cnt_d = '0;
            state_d     = StWait;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output register and handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ch_out_d    = ch_out_q;
    sel_err_d   = en && !mode && slot_free && !sel_ok;

    if (load) begin
      out_valid_d = 1'b1;
      dout_d      = cap_data;
      ch_out_d    = cap_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      scan_ptr_q  <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ch_out_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ch_out_q    <= ch_out_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ch_out    = ch_out_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scan_reg.sv
// Testbench for mux_nx1_scan_reg. Two instances share all control inputs:
// u8 (8 channels x 4 bits) and u6 (6 channels x 4 bits, non-power-of-two select range).
module tb_mux_nx1_scan_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din8;
  logic [2:0]  sel;
  logic        mode;
  logic        en;
  logic [3:0]  dwell;
  logic        out_ready;

  logic        u8_valid, u6_valid;
  logic [3:0]  u8_dout, u6_dout;
  logic [2:0]  u8_ch, u6_ch;
  logic        u8_err, u6_err;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = u8, 1 = u6.
  bit      m_valid[2];
  int      m_dout[2];
  int      m_ch[2];
  bit      m_err[2];
  int      m_ptr[2];
  int      m_cnt[2];
  bit      m_pmode[2];

  always #5 clk = ~clk;

  mux_nx1_scan_reg #(.N_CH(8), .WIDTH(4), .DWELL_W(4)) u8 (
    .clk       (clk),
    .rst       (rst),
    .din       (din8),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .dwell     (dwell),
    .out_ready (out_ready),
    .out_valid (u8_valid),
    .dout      (u8_dout),
    .ch_out    (u8_ch),
    .sel_err   (u8_err)
  );

  mux_nx1_scan_reg #(.N_CH(6), .WIDTH(4), .DWELL_W(4)) u6 (
    .clk       (clk),
    .rst       (rst),
    .din       (din8[23:0]),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .dwell     (dwell),
    .out_ready (out_ready),
    .out_valid (u6_valid),
    .dout      (u6_dout),
    .ch_out    (u6_ch),
    .sel_err   (u6_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of reference behaviour, evaluated on the inputs present before the edge.
  task automatic model_step(input int i, input int nch);
    bit rise, sf, ld, err;
    int c;
    if (rst) begin
      m_valid[i] = 0; m_dout[i] = 0; m_ch[i] = 0; m_err[i] = 0;
      m_ptr[i] = 0; m_cnt[i] = 0; m_pmode[i] = 0;
      return;
    end
    rise = mode && !m_pmode[i];
    m_pmode[i] = mode;
    if (rise) begin
      m_ptr[i] = 0;
      m_cnt[i] = 0;
    end
    sf  = !m_valid[i] || out_ready;
    ld  = 0;
    err = 0;
    c   = 0;
    if (!mode) begin
      m_cnt[i] = 0;
      if (en && sf) begin
        if (int'(sel) < nch) begin
          ld = 1;
          c  = int'(sel);
        end else begin
          err = 1;
        end
      end
    end else if (!en) begin
      m_cnt[i] = 0;
    end else if (m_cnt[i] < int'(dwell)) begin
      m_cnt[i]++;
    end else if (sf) begin
      ld = 1;
      c  = m_ptr[i];
      m_ptr[i] = (m_ptr[i] + 1) % nch;
      m_cnt[i] = 0;
    end
    if (ld) begin
      m_valid[i] = 1;
      m_dout[i]  = int'((din8 >> (4 * c)) & 32'hF);
      m_ch[i]    = c;
    end else if (out_ready) begin
      m_valid[i] = 0;
    end
    m_err[i] = err;
  endtask

  task automatic step();
    model_step(0, 8);
    model_step(1, 6);
    @(posedge clk);
    #1;
    check("u8_valid", 32'(u8_valid), 32'(m_valid[0]));
    check("u8_dout",  32'(u8_dout),  32'(m_dout[0]));
    check("u8_ch",    32'(u8_ch),    32'(m_ch[0]));
    check("u8_err",   32'(u8_err),   32'(m_err[0]));
    check("u6_valid", 32'(u6_valid), 32'(m_valid[1]));
    check("u6_dout",  32'(u6_dout),  32'(m_dout[1]));
    check("u6_ch",    32'(u6_ch),    32'(m_ch[1]));
    check("u6_err",   32'(u6_err),   32'(m_err[1]));
  endtask

  initial begin
    int exp_ch;
    int frozen_ch;
    int frozen_dout;

    // T1: reset with enable active and all-ones data.
    rst = 1; en = 1; mode = 0; sel = 3'd2; dwell = 4'd0; out_ready = 1; din8 = '1;
    step();
    step();
    check("t1_valid", 32'(u8_valid), 0);
    check("t1_dout",  32'(u8_dout),  0);
    check("t1_ch",    32'(u8_ch),    0);
    check("t1_err",   32'(u8_err),   0);

    // T2: MANUAL sweep, channel k carries k+3.
    rst = 0;
    for (int k = 0; k < 8; k++) din8[4*k +: 4] = 4'(k + 3);
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      step();
      check("t2_valid", 32'(u8_valid), 1);
      check("t2_dout",  32'(u8_dout),  32'(k + 3));
      check("t2_ch",    32'(u8_ch),    32'(k));
    end

    // T3: SCAN with dwell 2, capture every third clock in order 0..7 then 0.
    mode = 1; dwell = 4'd2;
    exp_ch = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      check("t3_pulse", 32'(u8_valid), 32'((n % 3) == 2));
      if (u8_valid) begin
        check("t3_order", 32'(u8_ch), 32'(exp_ch % 8));
        exp_ch++;
      end
    end

    // T4: backpressure with dwell 0.
    dwell = 4'd0;
    step();
    out_ready = 0;
    step();
    frozen_ch   = int'(u8_ch);
    frozen_dout = int'(u8_dout);
    for (int n = 0; n < 5; n++) begin
      step();
      check("t4_hold_ch",   32'(u8_ch),   32'(frozen_ch));
      check("t4_hold_dout", 32'(u8_dout), 32'(frozen_dout));
      check("t4_hold_vld",  32'(u8_valid), 1);
    end
    out_ready = 1;
    step();
    check("t4_resume", 32'(u8_ch), 32'((frozen_ch + 1) % 8));

    // T5: out-of-range select on the 6-channel instance.
    mode = 0; en = 0;
    step();
    en = 1; sel = 3'd7;
    step();
    check("t5_err",   32'(u6_err),   1);
    check("t5_valid", 32'(u6_valid), 0);
    sel = 3'd5;
    step();
    check("t5_err_clr", 32'(u6_err),   0);
    check("t5_cap_vld", 32'(u6_valid), 1);
    check("t5_cap_ch",  32'(u6_ch),    5);
    check("t5_cap_dat", 32'(u6_dout),  8);

    // T6: reset during a SCAN stall, then mode 0->1 restarts at channel 0.
    mode = 1; out_ready = 0;
    for (int n = 0; n < 4; n++) step();
    check("t6_stalled", 32'(u8_valid), 1);
    rst = 1;
    step();
    check("t6_rst_vld", 32'(u8_valid), 0);
    rst = 0; mode = 0; out_ready = 1; en = 0;
    step();
    mode = 1; en = 1;
    step();
    check("t6_restart_vld", 32'(u8_valid), 1);
    check("t6_restart_ch",  32'(u8_ch),    0);

    // Randomised traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(99) == 0);
      en        = ($urandom_range(9) != 0);
      if ($urandom_range(29) == 0) mode = ~mode;
      if ($urandom_range(19) == 0) dwell = 4'($urandom_range(3));
      sel       = 3'($urandom);
      out_ready = ($urandom_range(9) < 7);
      din8      = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
